// File: rtl/shift_pipe.sv
// shift_pipe: S-stage pipelined barrel shifter (left / logical right / arithmetic right)
// with a sticky flag collecting every bit shifted past the result boundary.
// Stage i shifts by 2^i when amount bit i is set; valid/ready flow control collapses bubbles.
module shift_pipe #(
  parameter int unsigned N = 16,
  parameter int unsigned S = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [S-1:0] in_amt,
  input  logic         in_dir,
  input  logic         in_arith,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_sticky
);

  localparam int          NI   = int'(N);
  localparam int          SI   = int'(S);
  localparam logic [N-1:0] ONES = '1;

  // per-stage registers
  logic [S-1:0] v_q;
  logic [S-1:0] dir_q;
  logic [S-1:0] ar_q;
  logic [S-1:0] st_q;
  logic [N-1:0] d_q [S];
  logic [S-1:0] a_q [S];

  // per-stage inputs (stage 0 from ports, stage i from stage i-1) and next values
  logic [S-1:0] adv;
  logic [S-1:0] x_v;
  logic [S-1:0] x_dir;
  logic [S-1:0] x_ar;
  logic [S-1:0] x_st;
  logic [N-1:0] x_d [S];
  logic [S-1:0] x_a [S];
  logic [S-1:0] n_st;
  logic [N-1:0] n_d [S];

  // advance chain: a stage moves when empty or when its successor moves
  always_comb begin
    adv      = '0;
    adv[S-1] = ~v_q[S-1] | out_ready;
    for (int k = SI - 2; k >= 0; k--) begin
      adv[k] = ~v_q[k] | adv[k+1];
    end
  end

  assign in_ready = rst_n & adv[0];

  // route each stage's operand and control from its predecessor
  always_comb begin
    x_v   = '0;
    x_dir = '0;
    x_ar  = '0;
    x_st  = '0;
    for (int i = 0; i < SI; i++) begin
      x_d[i] = '0;
      x_a[i] = '0;
    end
    x_v[0]   = in_valid & in_ready;
    x_d[0]   = in_data;
    x_a[0]   = in_amt;
    x_dir[0] = in_dir;
    x_ar[0]  = in_arith;
    x_st[0]  = 1'b0;
    for (int i = 1; i < SI; i++) begin
      x_v[i]   = v_q[i-1];
      x_d[i]   = d_q[i-1];
      x_a[i]   = a_q[i-1];
      x_dir[i] = dir_q[i-1];
      x_ar[i]  = ar_q[i-1];
      x_st[i]  = st_q[i-1];
    end
  end

  // conditional 2^i shift per stage; out_m marks the bits that leave the word.
  // For arithmetic right shifts only original operand bits below the sign position
  // count: earlier stages already put c = amt[i-1:0] fill copies above it.
  always_comb begin
    int          k;
    int          c;
    int          lim;
    logic [N-1:0] out_m;
    k     = 0;
    c     = 0;
    lim   = 0;
    out_m = '0;
    for (int i = 0; i < SI; i++) begin
      n_d[i]  = x_d[i];
      n_st[i] = x_st[i];
      if (x_a[i][i]) begin
        k = 1 << i;
        c = int'(x_a[i]) & (k - 1);
        if (!x_dir[i]) begin
          n_d[i] = x_d[i] << k;
          out_m  = ~(ONES >> k);
        end else if (!x_ar[i]) begin
          n_d[i] = x_d[i] >> k;
          out_m  = ~(ONES << k);
        end else begin
          n_d[i] = $signed(x_d[i]) >>> k;
          lim    = NI - 1 - c;
          if (k < lim) lim = k;
          if (lim < 0) lim = 0;
          out_m  = ~(ONES << lim);
        end
        n_st[i] = x_st[i] | (|(x_d[i] & out_m));
      end
    end
  end

  // stage registers: only valids and the output stage are reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q      <= '0;
      d_q[S-1] <= '0;
      st_q[S-1] <= 1'b0;
    end else begin
      for (int i = 0; i < SI; i++) begin
        if (adv[i]) begin
          v_q[i] <= x_v[i];
          if (x_v[i]) begin
            d_q[i]   <= n_d[i];
            a_q[i]   <= x_a[i];
            dir_q[i] <= x_dir[i];
            ar_q[i]  <= x_ar[i];
            st_q[i]  <= n_st[i];
          end
        end
      end
    end
  end

  assign out_valid  = v_q[S-1];
  assign out_data   = d_q[S-1];
  assign out_sticky = st_q[S-1];

  // last-stage control travels with the result but has no consumer
  logic unused_ctl;
  assign unused_ctl = ^{a_q[S-1], dir_q[S-1], ar_q[S-1]};

endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: scoreboard bench for shift_pipe (N=16/S=4 and N=12/S=4 instances).
module tb_shift_pipe;

  localparam int unsigned N  = 16;
  localparam int unsigned S  = 4;
  localparam int unsigned N2 = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready, in_dir = 1'b0, in_arith = 1'b0;
  logic [N-1:0]  in_data = '0;
  logic [S-1:0]  in_amt = '0;
  logic          out_valid, out_ready = 1'b1, out_sticky;
  logic [N-1:0]  out_data;

  logic          b_valid = 1'b0, b_in_ready, b_dir = 1'b0, b_arith = 1'b0;
  logic [N2-1:0] b_data = '0;
  logic [S-1:0]  b_amt = '0;
  logic          b_out_valid, b_out_sticky;
  logic [N2-1:0] b_out_data;

  shift_pipe #(.N(N), .S(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .in_dir(in_dir), .in_arith(in_arith),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sticky(out_sticky)
  );

  shift_pipe #(.N(N2), .S(S)) dut12 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_in_ready),
    .in_data(b_data), .in_amt(b_amt), .in_dir(b_dir), .in_arith(b_arith),
    .out_valid(b_out_valid), .out_ready(1'b1), .out_data(b_out_data), .out_sticky(b_out_sticky)
  );

  typedef struct {
    logic [31:0] data;
    logic        sticky;
    int          cyc;
    bit          chk_lat;
  } exp_t;

  exp_t q16[$];
  exp_t q12[$];
  int   total = 0;
  int   passed = 0;
  int   cyc = 0;
  bit   lat_mode = 1'b0;
  bit   rand_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // reference: shift as arithmetic on a wide integer; sticky = original bits that left the word
  function automatic logic [32:0] ref_shift(input int w, input logic [31:0] din, input int amt,
                                            input bit dir, input bit ar);
    longint unsigned mask, full, d;
    longint          sx;
    logic [31:0]     r;
    logic            st;
    int              lim;
    mask = (64'd1 << w) - 64'd1;
    d    = {32'd0, din} & mask;
    if (!dir) begin
      full = d << amt;
      r    = 32'(full & mask);
      st   = (full >> w) != 0;
    end else if (!ar) begin
      lim = (amt < w) ? amt : w;
      r   = 32'(d >> amt);
      st  = (d & ((64'd1 << lim) - 64'd1)) != 0;
    end else begin
      lim = (amt < w - 1) ? amt : w - 1;
      sx  = longint'(d);
      if (d[w-1]) sx = sx | longint'(~mask);
      r   = 32'((sx >>> amt) & longint'(mask));
      st  = (d & ((64'd1 << lim) - 64'd1)) != 0;
    end
    return {st, r};
  endfunction

  // monitor / scoreboard for the 16-bit instance
  logic          prev_stall = 1'b0;
  logic [N-1:0]  prev_d;
  logic          prev_s;
  always @(negedge clk) begin
    exp_t        e;
    logic [32:0] m;
    if (!rst_n) begin
      q16.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_result", 64'({out_data, out_sticky}), 64'({prev_d, prev_s}));
      end
      if (out_valid && out_ready) begin
        if (q16.size() == 0) check("spurious_output", 64'(out_valid), 64'd0);
        else begin
          e = q16.pop_front();
          check("data16", 64'(out_data), 64'(e.data[N-1:0]));
          check("sticky16", 64'(out_sticky), 64'(e.sticky));
          if (e.chk_lat) check("latency16", 64'(cyc - e.cyc), 64'(S));
        end
      end
      if (in_valid && in_ready) begin
        m = ref_shift(int'(N), {16'd0, in_data}, int'(in_amt), in_dir, in_arith);
        e.data = m[31:0]; e.sticky = m[32]; e.cyc = cyc; e.chk_lat = lat_mode && out_ready;
        q16.push_back(e);
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      prev_s     = out_sticky;
    end
  end

  // monitor / scoreboard for the 12-bit instance (consumer always ready)
  always @(negedge clk) begin
    exp_t        e;
    logic [32:0] m;
    if (!rst_n) q12.delete();
    else begin
      if (b_out_valid) begin
        if (q12.size() == 0) check("spurious_output12", 64'(b_out_valid), 64'd0);
        else begin
          e = q12.pop_front();
          check("data12", 64'(b_out_data), 64'(e.data[N2-1:0]));
          check("sticky12", 64'(b_out_sticky), 64'(e.sticky));
          check("latency12", 64'(cyc - e.cyc), 64'(S));
        end
      end
      if (b_valid && b_in_ready) begin
        m = ref_shift(int'(N2), {20'd0, b_data}, int'(b_amt), b_dir, b_arith);
        e.data = m[31:0]; e.sticky = m[32]; e.cyc = cyc; e.chk_lat = 1'b1;
        q12.push_back(e);
      end
    end
  end

  // random consumer back-pressure
  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit w12, input logic [15:0] d, input logic [3:0] a,
                      input bit dr, input bit ar);
    bit hs;
    int n;
    hs = 1'b0;
    n  = 0;
    if (w12) begin
      b_valid = 1'b1; b_data = d[11:0]; b_amt = a; b_dir = dr; b_arith = ar;
    end else begin
      in_valid = 1'b1; in_data = d; in_amt = a; in_dir = dr; in_arith = ar;
    end
    do begin
      @(negedge clk);
      hs = w12 ? b_in_ready : in_ready;
      tick();
      n++;
    end while (!hs && n < 200);
    if (!hs) check("send_timeout", 64'(hs), 64'd1);
    if (w12) b_valid = 1'b0;
    else in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (q16.size() != 0 || q12.size() != 0); i++) tick();
    check("drain16", 64'(q16.size()), 64'd0);
    check("drain12", 64'(q12.size()), 64'd0);
  endtask

  task automatic rand_op();
    in_data = 16'($urandom); in_amt = 4'($urandom);
    in_dir = 1'($urandom); in_arith = 1'($urandom);
  endtask

  logic [15:0] dir_d [10] = '{16'h8001, 16'h8010, 16'h8010, 16'h1234, 16'hFFFF,
                              16'h8000, 16'h8000, 16'h7FFF, 16'h00F0, 16'hA5A5};
  logic [3:0]  dir_a [10] = '{4'd1, 4'd4, 4'd5, 4'd0, 4'd15, 4'd15, 4'd15, 4'd15, 4'd4, 4'd8};
  bit          dir_r [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  bit          dir_s [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    bit hs;
    int acc;

    // reset
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_in_ready12", 64'(b_in_ready), 64'd0);
    repeat (2) tick();
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_sticky", 64'(out_sticky), 64'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    tick();

    // directed operations, consumer always ready: exact latency checked
    lat_mode = 1'b1;
    for (int i = 0; i < 10; i++) send(1'b0, dir_d[i], dir_a[i], dir_r[i], dir_s[i]);
    drain();

    // 12-bit instance: logical right by 15 of 0x001, then random ops (amounts >= 12 included)
    send(1'b1, 16'h0001, 4'd15, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++)
      send(1'b1, 16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));

    // 8 back-to-back ops
    for (int i = 0; i < 8; i++)
      send(1'b0, 16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
    drain();

    // stall: consumer blocks for several cycles while a producer streams
    lat_mode = 1'b0;
    out_ready = 1'b0;
    acc = 0;
    in_valid = 1'b1;
    rand_op();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      hs = in_ready;
      if (hs) acc++;
      tick();
      if (hs) rand_op();
    end
    @(negedge clk);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_accepted", 64'(acc), 64'(S));
    tick();
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      hs = in_ready;
      tick();
      if (hs) rand_op();
    end
    in_valid = 1'b0;
    drain();

    // reset with three operations in flight
    for (int i = 0; i < 3; i++)
      send(1'b0, 16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    repeat (10) tick();

    // randomized traffic with random back-pressure
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(1'b0, 16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
    end
    rand_mode = 1'b0;
    repeat (2) tick();
    out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", passed, total);
    $fatal(1);
  end

endmodule

// File: doc/shift_pipe.md
SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
Parameters:
REQ-001 SHALL provide parameter N, default 16: data width in bits, N >= 2.
REQ-002 SHALL provide parameter S, default 4: shift-amount width; shift stage count; latency in cycles; S >= 1.

Ports:
REQ-003 SHALL provide clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL provide rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL provide in_valid  input  1  input operation present.
REQ-006 SHALL provide in_ready  output  1  block accepts the input this cycle.
REQ-007 SHALL provide in_data  input  N  operand.
REQ-008 SHALL provide in_amt  input  S  unsigned shift amount.
REQ-009 SHALL provide in_dir  input  1  0 = left, 1 = right.
REQ-010 SHALL provide in_arith  input  1  right shifts only: 1 = sign-fill, 0 = zero-fill; ignored for left shifts.
REQ-011 SHALL provide out_valid  output  1  result present.
REQ-012 SHALL provide out_ready  input  1  consumer accepts the result.
REQ-013 SHALL provide out_data  output  N  shifted result.
REQ-014 SHALL provide out_sticky  output  1  OR of all bits shifted out past the result boundary, either direction.

Function
REQ-015 SHALL implement S pipeline stages; stage i conditionally shifts by 2^i per bit i of the amount, then registers data, amount, dir, arith, sticky and valid.
REQ-016 SHALL have latency exactly S cycles from input handshake (in_valid & in_ready) to out_valid, with no stalls.
REQ-017 SHALL sustain one accepted operation per cycle while out_ready is held high.
REQ-018 SHALL advance stage k when it is empty or stage k+1 advances; the last stage advances when it is empty or out_ready is high (bubble-collapsing).
REQ-019 SHALL drive in_ready = stage 0 advance condition, combinationally, and SHALL NOT make in_ready depend on in_valid.
REQ-020 SHALL hold a stalled stage's data, flags and valid unchanged.
REQ-021 SHALL keep out_data and out_sticky stable while out_valid is high and out_ready is low.
REQ-022 SHALL fill left shifts with 0 from the LSB end.
REQ-023 SHALL fill right shifts with 0 from the MSB end when in_arith = 0, and with the original operand MSB when in_arith = 1.
REQ-024 SHALL produce all-fill data when the shift amount is >= N (possible when 2^S > N); sticky is then the OR of all operand bits, excluding bits equal to the fill for arithmetic right shifts.
REQ-025 SHALL define sticky for arithmetic right shifts as the OR of the shifted-out bits; sign fill does not contribute.
REQ-026 SHALL give amount 0 the result data = operand and sticky = 0.
REQ-027 SHALL carry each operation's dir and arith with it; consecutive operations with different modes SHALL NOT interfere.
REQ-028 SHALL allow simultaneous input and output handshakes in one cycle, with no loss or duplication.

Reset
REQ-029 SHALL clear every stage valid on a clk edge with rst_n low, giving out_valid = 0, out_data = 0 and out_sticky = 0.
REQ-030 SHALL drive in_ready low while rst_n is low, and high on the first cycle after release.
REQ-031 SHALL discard any operation in flight when reset is asserted mid-operation; no result emerges after release.
REQ-032 SHALL require no reset of datapath registers other than the output registers.

Verification
REQ-033 SHALL be covered by this scenario: N=16, S=4, left, in_data=0x8001, amt=1 -> 4 cycles later out_data=0x0002, sticky=1.
REQ-034 SHALL be covered by this scenario: right arith, in_data=0x8010, amt=4 -> out_data=0xF801, sticky=0; amt=5 -> out_data=0xFC00, sticky=1.
REQ-035 SHALL be covered by this scenario: N=12, S=4, right logical, amt=15, in_data=0x001 -> out_data=0x000, sticky=1.
REQ-036 SHALL be covered by this scenario: 8 back-to-back ops with out_ready=1 -> 8 consecutive out_valid cycles, in order, 4-cycle latency.
REQ-037 SHALL be covered by this scenario: out_ready low for 6 cycles while streaming -> pipeline fills, in_ready falls after 4 accepted ops, output held stable, no loss or reorder when out_ready returns.
REQ-038 SHALL be covered by this scenario: rst_n low 1 cycle with 3 ops in flight -> out_valid=0 next cycle, no stale results afterward.
